// File: rtl/jtpopeye_pkg.sv
// Shared definitions for the Popeye tile/sprite RAM paths: the background
// write-sequencer state encoding and the nibble-merge helper.
package jtpopeye_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_CAP  = 2'd2,
    ST_WR   = 2'd3
  } bck_st_t;

  // Replace one nibble of the stored byte with the matching nibble of din.
  function automatic logic [7:0] nib_merge(input logic       hi,
                                           input logic [7:0] din,
                                           input logic [7:0] old);
    return hi ? {din[7:4], old[3:0]} : {old[7:4], din[3:0]};
  endfunction

endpackage

// File: rtl/jtpopeye_bck_arb.sv
// Background tile RAM arbiter: video reads always win the RAM in their own
// cycle; CPU nibble writes run as a read-modify-write that yields to video.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | no write pending; buffer accepts a new CPU nibble write
// RD    | present buffered address for read (stalls on vid_req)
// CAP   | capture RAM data into old_q; RAM free for video
// WR    | write merged byte, pulse cpu_done (stalls on vid_req)
module jtpopeye_bck_arb #(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic [7:0]    vid_dout,
  output logic          vid_ok,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic          cpu_hi,
  input  logic [7:0]    cpu_din,
  output logic          cpu_busy,
  output logic          cpu_done,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [7:0]    ram_din,
  input  logic [7:0]    ram_dout
);
  import jtpopeye_pkg::*;

  bck_st_t       st, st_nx;
  logic [AW-1:0] buf_addr;
  logic          buf_hi;
  logic [7:0]    buf_din;
  logic [7:0]    old_q;
  logic          rd_pend;
  logic          accept;

  assign cpu_busy = (st != ST_IDLE);
  assign accept   = cpu_we & ~cpu_busy;
  assign ram_din  = nib_merge(buf_hi, buf_din, old_q);

  // Next state and RAM grant; video overrides everything, reset blocks writes.
  always_comb begin
    st_nx    = st;
    ram_addr = buf_addr;
    ram_we   = 1'b0;
    cpu_done = 1'b0;
    case (st)
      ST_IDLE: if (accept) st_nx = ST_RD;
      ST_RD:   if (!vid_req) st_nx = ST_CAP;
      ST_CAP:  st_nx = ST_WR;
      ST_WR: begin
        if (!vid_req) begin
          ram_we   = 1'b1;
          cpu_done = 1'b1;
          st_nx    = ST_IDLE;
        end
      end
      default: st_nx = ST_IDLE;
    endcase
    if (vid_req) begin
      ram_addr = vid_addr;
      ram_we   = 1'b0;
    end
    if (rst) begin
      ram_we   = 1'b0;
      cpu_done = 1'b0;
    end
  end

  // Sequencer state, write buffer and captured old byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= ST_IDLE;
      buf_addr <= '0;
      buf_hi   <= 1'b0;
      buf_din  <= 8'd0;
      old_q    <= 8'd0;
    end else begin
      st <= st_nx;
      if (accept) begin
        buf_addr <= cpu_addr;
        buf_hi   <= cpu_hi;
        buf_din  <= cpu_din;
      end
      if (st == ST_CAP) old_q <= ram_dout;
    end
  end

  // Fixed two-cycle video read pipeline, independent of the CPU sequencer.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend  <= 1'b0;
      vid_ok   <= 1'b0;
      vid_dout <= 8'd0;
    end else begin
      rd_pend <= vid_req;
      vid_ok  <= rd_pend;
      if (rd_pend) vid_dout <= ram_dout;
    end
  end

endmodule

// File: tb/tb_jtpopeye_bck_arb.sv
// Directed bench for the background RAM arbiter with a behavioural RAM.
module tb_jtpopeye_bck_arb;
  logic        clk = 1'b0;
  logic        rst;
  logic        vid_req;
  logic [11:0] vid_addr;
  logic [7:0]  vid_dout;
  logic        vid_ok;
  logic        cpu_we;
  logic [11:0] cpu_addr;
  logic        cpu_hi;
  logic [7:0]  cpu_din;
  logic        cpu_busy;
  logic        cpu_done;
  logic [11:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  mem [4096];
  logic        pl_en = 1'b0;
  logic [11:0] pl_addr = '0;
  logic [7:0]  pl_data = '0;

  always #5 clk = ~clk;

  jtpopeye_bck_arb #(.AW(12)) dut (
    .clk(clk), .rst(rst),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_dout(vid_dout), .vid_ok(vid_ok),
    .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_hi(cpu_hi), .cpu_din(cpu_din),
    .cpu_busy(cpu_busy), .cpu_done(cpu_done),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // Single-port synchronous RAM, read-first, plus a bench preload port.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    else if (pl_en) mem[pl_addr] <= pl_data;
    ram_dout <= mem[ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in;
    vid_req = 1'b0; vid_addr = '0;
    cpu_we = 1'b0; cpu_addr = '0; cpu_hi = 1'b0; cpu_din = '0;
  endtask

  task automatic preload(input logic [11:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  // 16-cycle write sequence with video reads at 0x300+c where vmask[c] is set.
  task automatic write_seq(input logic [11:0] a, input logic hi, input logic [7:0] din,
                           input logic [15:0] vmask, input int exp_done,
                           input logic [7:0] exp_byte, input logic drop);
    logic [7:0] vdexp [16];
    int done_cnt;
    int done_at;
    done_cnt = 0;
    done_at  = -1;
    for (int c = 0; c < 16; c++) begin
      idle_in();
      vid_req  = vmask[c];
      vid_addr = 12'h300 + 12'(c);
      vdexp[c] = mem[12'h300 + 12'(c)];
      if (c == 0) begin
        cpu_we = 1'b1; cpu_addr = a; cpu_hi = hi; cpu_din = din;
      end
      if (drop && c == 2) begin
        cpu_we = 1'b1; cpu_addr = 12'h041; cpu_hi = 1'b0; cpu_din = 8'hFF;
      end
      #1;
      chk("seq_busy", 32'(cpu_busy), 32'(c >= 1 && c <= exp_done));
      if (c >= 2) begin
        chk("seq_vid_ok", 32'(vid_ok), 32'(vmask[c-2]));
        if (vmask[c-2]) chk("seq_vid_dout", 32'(vid_dout), 32'(vdexp[c-2]));
      end
      if (vid_req) chk("seq_vid_prio", 32'({ram_we, ram_addr}), 32'({1'b0, vid_addr}));
      if (cpu_done) begin
        done_cnt++;
        done_at = c;
        chk("seq_wr_din", 32'(ram_din), 32'(exp_byte));
        chk("seq_wr_addr", 32'(ram_addr), 32'(a));
      end
      chk("seq_we_done", 32'(ram_we), 32'(cpu_done));
      tick();
    end
    idle_in();
    chk("seq_done_cycle", 32'(done_at), 32'(exp_done));
    chk("seq_done_count", 32'(done_cnt), 32'd1);
    chk("seq_ram_byte", 32'(mem[a]), 32'(exp_byte));
  endtask

  typedef struct {
    logic        vr;
    logic [11:0] va;
    logic        we;
    logic [11:0] ca;
    logic        hi;
    logic [7:0]  din;
    logic        e_we;
    logic [11:0] e_addr;
    logic [7:0]  e_din;
    logic        e_busy;
    logic        e_done;
    logic        e_ok;
    logic [7:0]  e_vd;
  } vec_t;

  vec_t tv [12];

  initial begin
    rst = 1'b1;
    idle_in();
    // vector table: two uncontended writes to 0x123 then a video read of it
    tv[0]  = '{1'b0, 12'h000, 1'b1, 12'h123, 1'b0, 8'h3C, 1'b0, 12'h000, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
    tv[1]  = '{1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 8'h00, 1'b0, 12'h123, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00};
    tv[2]  = '{1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 8'h00, 1'b0, 12'h123, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00};
    tv[3]  = '{1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 8'h00, 1'b1, 12'h123, 8'hAC, 1'b1, 1'b1, 1'b0, 8'h00};
    tv[4]  = '{1'b0, 12'h000, 1'b1, 12'h123, 1'b1, 8'h7F, 1'b0, 12'h123, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
    tv[5]  = '{1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 8'h00, 1'b0, 12'h123, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00};
    tv[6]  = '{1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 8'h00, 1'b0, 12'h123, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00};
    tv[7]  = '{1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 8'h00, 1'b1, 12'h123, 8'h7C, 1'b1, 1'b1, 1'b0, 8'h00};
    tv[8]  = '{1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 8'h00, 1'b0, 12'h123, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
    tv[9]  = '{1'b1, 12'h123, 1'b0, 12'h000, 1'b0, 8'h00, 1'b0, 12'h123, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
    tv[10] = '{1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 8'h00, 1'b0, 12'h123, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
    tv[11] = '{1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 8'h00, 1'b0, 12'h123, 8'h00, 1'b0, 1'b0, 1'b1, 8'h7C};

    tick();
    preload(12'h123, 8'hA5);
    preload(12'h040, 8'h11);
    preload(12'h041, 8'h22);
    preload(12'h050, 8'h9B);
    preload(12'h060, 8'h3C);
    preload(12'h0FF, 8'h77);
    preload(12'h200, 8'h55);
    for (int i = 0; i < 16; i++) preload(12'h300 + 12'(i), 8'(i * 7 + 3));
    rst = 1'b0;

    // reset state and idle
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("rst_outputs", 32'({vid_ok, vid_dout, cpu_busy, cpu_done, ram_we, ram_addr, ram_din}), 32'd0);
      tick();
    end

    // table-driven uncontended writes
    for (int i = 0; i < 12; i++) begin
      vid_req = tv[i].vr; vid_addr = tv[i].va;
      cpu_we = tv[i].we; cpu_addr = tv[i].ca; cpu_hi = tv[i].hi; cpu_din = tv[i].din;
      #1;
      chk("tv_ram_we", 32'(ram_we), 32'(tv[i].e_we));
      chk("tv_ram_addr", 32'(ram_addr), 32'(tv[i].e_addr));
      if (tv[i].e_we) chk("tv_ram_din", 32'(ram_din), 32'(tv[i].e_din));
      chk("tv_busy", 32'(cpu_busy), 32'(tv[i].e_busy));
      chk("tv_done", 32'(cpu_done), 32'(tv[i].e_done));
      chk("tv_vid_ok", 32'(vid_ok), 32'(tv[i].e_ok));
      if (tv[i].e_ok) chk("tv_vid_dout", 32'(vid_dout), 32'(tv[i].e_vd));
      tick();
    end
    idle_in();
    chk("tv_mem_123", 32'(mem[12'h123]), 32'h7C);

    // contended writes; the first also tries a dropped write to 0x041
    write_seq(12'h040, 1'b1, 8'hE0, 16'h2AAA, 4, 8'hE1, 1'b1);
    chk("drop_mem_041", 32'(mem[12'h041]), 32'h22);
    write_seq(12'h050, 1'b0, 8'h04, 16'h0012, 5, 8'h94, 1'b0);
    write_seq(12'h060, 1'b1, 8'hA7, 16'h0036, 6, 8'hAC, 1'b0);

    // reset while in CAP, with a video read in flight
    cpu_we = 1'b1; cpu_addr = 12'h0FF; cpu_hi = 1'b1; cpu_din = 8'h10;
    tick();
    idle_in();
    tick();
    rst = 1'b1; vid_req = 1'b1; vid_addr = 12'h301;
    #1;
    chk("rst_cap_we", 32'(ram_we), 32'd0);
    tick();
    rst = 1'b0; idle_in();
    for (int c = 0; c < 6; c++) begin
      #1;
      chk("rst_mid_state", 32'({cpu_busy, cpu_done, ram_we, vid_ok}), 32'd0);
      tick();
    end
    chk("rst_mid_mem", 32'(mem[12'h0FF]), 32'h77);

    // video and CPU hit 0x200 in the same cycle
    vid_req = 1'b1; vid_addr = 12'h200;
    cpu_we = 1'b1; cpu_addr = 12'h200; cpu_hi = 1'b0; cpu_din = 8'h0A;
    #1;
    chk("coh_prio_addr", 32'(ram_addr), 32'h200);
    tick();
    idle_in();
    for (int c = 1; c < 6; c++) begin
      #1;
      chk("coh_vid_ok", 32'(vid_ok), 32'(c == 2));
      if (c == 2) chk("coh_vid_dout", 32'(vid_dout), 32'h55);
      chk("coh_done", 32'(cpu_done), 32'(c == 3));
      tick();
    end
    chk("coh_mem_200", 32'(mem[12'h200]), 32'h5A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
